combo_lock_param: RTL and testbench

//  Parametrised successor to the single-code combination lock. Accepts a code of NUM_DIGITS digits of DIGIT_W bits,
//  and reveals no per-digit progress: a verdict is given only after all digits are entered.

---
 rtl/combo_lock_param.sv | 202 ++++++++++++++++++++
 tb/tb_combo_lock_param.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_param.sv
// rtl/combo_lock_param.sv - parametrised combination lock with timeout, lockout and reprogramming
module combo_lock_param #(
  parameter int DIGIT_W = 4,
  parameter int NUM_DIGITS = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_CODE = {4'h8, 4'h4, 4'h2, 4'h1},
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 500,
  localparam int CNT_W = $clog2(NUM_DIGITS + 1)
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               DIGIT_VALID,
  input  logic [DIGIT_W-1:0] DIGIT,
  input  logic               RELOCK,
  input  logic               PROG,
  output logic               OPEN,
  output logic               FAIL,
  output logic               LOCKOUT,
  output logic               PROGRAMMING,
  output logic [CNT_W-1:0]   DIGITS_ENTERED
);

  localparam int CODE_W  = DIGIT_W * NUM_DIGITS;
  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int TMR_MAX = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0]  LAST_IDX     = CNT_W'(NUM_DIGITS - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCKOUT_LAST = TMR_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_PROGRAM = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [CODE_W-1:0]   code, code_n;
  logic [CODE_W-1:0]   shadow, shadow_n, shadow_wr;
  logic [CNT_W-1:0]    cnt, cnt_n, idx;
  logic                mism, mism_n, miss, accept, fail_n;
  logic [FAIL_W-1:0]   fails, fails_n, fails_inc;
  logic [TMR_W-1:0]    timer, timer_n;

  // Digit i of a code; digit 0 lives in the MSBs.
  function automatic logic [DIGIT_W-1:0] digit_at(input logic [CODE_W-1:0] v,
                                                  input logic [CNT_W-1:0] i);
    logic [DIGIT_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (int'(i) == k) r = v[(NUM_DIGITS-1-k)*DIGIT_W +: DIGIT_W];
    return r;
  endfunction

  // Copy of a code with digit slot i replaced by d.
  function automatic logic [CODE_W-1:0] with_digit(input logic [CODE_W-1:0] v,
                                                   input logic [CNT_W-1:0] i,
                                                   input logic [DIGIT_W-1:0] d);
    logic [CODE_W-1:0] r;
    r = v;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (int'(i) == k) r[(NUM_DIGITS-1-k)*DIGIT_W +: DIGIT_W] = d;
    return r;
  endfunction

  // Next-state logic; a verdict is only produced once the last digit arrives.
  always_comb begin
    state_n   = state;
    code_n    = code;
    shadow_n  = shadow;
    cnt_n     = cnt;
    mism_n    = mism;
    fails_n   = fails;
    timer_n   = timer;
    fail_n    = 1'b0;
    accept    = 1'b0;
    idx       = (state == S_ENTRY) ? cnt : '0;
    miss      = (DIGIT != digit_at(code, idx)) || ((state == S_ENTRY) && mism);
    shadow_wr = with_digit(shadow, cnt, DIGIT);
    fails_inc = (fails == FAIL_LIMIT) ? fails : fails + 1'b1;

    case (state)
      S_IDLE: begin
        if (!RELOCK && DIGIT_VALID) accept = 1'b1;
      end
      S_ENTRY: begin
        if (RELOCK) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          mism_n  = 1'b0;
          timer_n = '0;
        end else if (DIGIT_VALID) begin
          accept = 1'b1;
        end else if (timer == TIMEOUT_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          mism_n  = 1'b0;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_OPEN: begin
        if (RELOCK) begin
          state_n = S_IDLE;
        end else if (PROG) begin
          state_n  = S_PROGRAM;
          cnt_n    = '0;
          shadow_n = code;
        end
      end
      S_PROGRAM: begin
        if (RELOCK) begin
          state_n  = S_IDLE;
          cnt_n    = '0;
          shadow_n = code;
        end else if (DIGIT_VALID) begin
          if (cnt == LAST_IDX) begin
            code_n  = shadow_wr;
            state_n = S_OPEN;
            cnt_n   = '0;
          end else begin
            shadow_n = shadow_wr;
            cnt_n    = cnt + 1'b1;
          end
        end
      end
      S_LOCKOUT: begin
        if (timer == LOCKOUT_LAST) begin
          state_n = S_IDLE;
          timer_n = '0;
          fails_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        mism_n  = 1'b0;
        timer_n = '0;
      end
    endcase

    if (accept) begin
      timer_n = '0;
      if (idx == LAST_IDX) begin
        cnt_n  = '0;
        mism_n = 1'b0;
        if (!miss) begin
          state_n = S_OPEN;
          fails_n = '0;
        end else begin
          fail_n  = 1'b1;
          fails_n = fails_inc;
          state_n = (fails_inc == FAIL_LIMIT) ? S_LOCKOUT : S_IDLE;
        end
      end else begin
        state_n = S_ENTRY;
        cnt_n   = idx + 1'b1;
        mism_n  = miss;
      end
    end
  end

  // State, code storage and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state          <= S_IDLE;
      code           <= DEFAULT_CODE;
      shadow         <= DEFAULT_CODE;
      cnt            <= '0;
      mism           <= 1'b0;
      fails          <= '0;
      timer          <= '0;
      OPEN           <= 1'b0;
      FAIL           <= 1'b0;
      LOCKOUT        <= 1'b0;
      PROGRAMMING    <= 1'b0;
      DIGITS_ENTERED <= '0;
    end else begin
      state          <= state_n;
      code           <= code_n;
      shadow         <= shadow_n;
      cnt            <= cnt_n;
      mism           <= mism_n;
      fails          <= fails_n;
      timer          <= timer_n;
      OPEN           <= (state_n == S_OPEN) || (state_n == S_PROGRAM);
      FAIL           <= fail_n;
      LOCKOUT        <= (state_n == S_LOCKOUT);
      PROGRAMMING    <= (state_n == S_PROGRAM);
      DIGITS_ENTERED <= ((state_n == S_ENTRY) || (state_n == S_PROGRAM)) ? cnt_n : '0;
    end
  end

endmodule

// File: tb/tb_combo_lock_param.sv
// tb/tb_combo_lock_param.sv - self-checking bench for combo_lock_param
module tb_combo_lock_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'h0;
  logic       relock = 1'b0;
  logic       prog = 1'b0;
  logic       lock_open, fail, lockout, programming;
  logic [2:0] digits_entered;

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] exp_q[$];

  combo_lock_param dut (
    .CLOCK_50      (clk),
    .RESET_N       (reset_n),
    .DIGIT_VALID   (digit_valid),
    .DIGIT         (digit),
    .RELOCK        (relock),
    .PROG          (prog),
    .OPEN          (lock_open),
    .FAIL          (fail),
    .LOCKOUT       (lockout),
    .PROGRAMMING   (programming),
    .DIGITS_ENTERED(digits_entered)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] st(input logic o, input logic f, input logic l,
                                    input logic p, input int de);
    return {o, f, l, p, de[2:0]};
  endfunction

  function automatic logic [6:0] status();
    return {lock_open, fail, lockout, programming, digits_entered};
  endfunction

  task automatic strobe_digit(input logic [3:0] d);
    @(negedge clk); digit_valid = 1'b1; digit = d;
    @(negedge clk); digit_valid = 1'b0;
  endtask

  task automatic pulse_relock();
    @(negedge clk); relock = 1'b1;
    @(negedge clk); relock = 1'b0;
  endtask

  task automatic pulse_prog();
    @(negedge clk); prog = 1'b1;
    @(negedge clk); prog = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(st(0, 0, 0, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL reset: got %b want %b", status(), e); end
  endtask

  task automatic test_open();
    logic [6:0] e;
    logic [15:0] c = 16'h8421;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i < 3 ? st(0, 0, 0, 0, i + 1) : st(1, 0, 0, 0, 0));
      strobe_digit(c[15-4*i -: 4]);
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL open_d%0d: got %b want %b", i, status(), e); end
    end
    exp_q.push_back(st(1, 0, 0, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL open_hold: got %b want %b", status(), e); end
    exp_q.push_back(st(0, 0, 0, 0, 0));
    pulse_relock();
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL open_relock: got %b want %b", status(), e); end
  endtask

  task automatic test_fail_lockout();
    logic [6:0] e;
    logic [15:0] c;
    for (int a = 1; a <= 3; a++) begin
      c = 16'h8521;
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(i < 3 ? st(0, 0, 0, 0, i + 1) : st(0, 1, a == 3, 0, 0));
        strobe_digit(c[15-4*i -: 4]);
        e = exp_q.pop_front(); vectors++;
        if (status() !== e) begin miscompares++; $display("FAIL bad_a%0d_d%0d: got %b want %b", a, i, status(), e); end
      end
      exp_q.push_back(st(0, 0, a == 3, 0, 0));
      @(negedge clk);
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL fail_drop_a%0d: got %b want %b", a, status(), e); end
    end
    c = 16'h8421;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(st(0, 0, 1, 0, 0));
      strobe_digit(c[15-4*i -: 4]);
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL lockout_ignore_d%0d: got %b want %b", i, status(), e); end
    end
    exp_q.push_back(st(0, 0, 1, 0, 0));
    repeat (990) @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL lockout_last: got %b want %b", status(), e); end
    exp_q.push_back(st(0, 0, 0, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL lockout_exit: got %b want %b", status(), e); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i < 3 ? st(0, 0, 0, 0, i + 1) : st(1, 0, 0, 0, 0));
      strobe_digit(c[15-4*i -: 4]);
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL post_lockout_d%0d: got %b want %b", i, status(), e); end
    end
    pulse_relock();
  endtask

  task automatic test_timeout();
    logic [6:0] e;
    logic [15:0] c = 16'h8421;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(st(0, 0, 0, 0, i + 1));
      strobe_digit(c[15-4*i -: 4]);
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL to_d%0d: got %b want %b", i, status(), e); end
    end
    exp_q.push_back(st(0, 0, 0, 0, 2));
    repeat (499) @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL to_before: got %b want %b", status(), e); end
    exp_q.push_back(st(0, 0, 0, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL to_expire: got %b want %b", status(), e); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i < 3 ? st(0, 0, 0, 0, i + 1) : st(1, 0, 0, 0, 0));
      strobe_digit(c[15-4*i -: 4]);
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL to_reopen_d%0d: got %b want %b", i, status(), e); end
    end
    pulse_relock();
  endtask

  task automatic test_program();
    logic [6:0] e;
    logic [15:0] c = 16'h8421;
    logic [15:0] n = 16'h3377;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i < 3 ? st(0, 0, 0, 0, i + 1) : st(1, 0, 0, 0, 0));
      strobe_digit(c[15-4*i -: 4]);
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL pg_open_d%0d: got %b want %b", i, status(), e); end
    end
    exp_q.push_back(st(1, 0, 0, 0, 0));
    strobe_digit(4'h5);
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL pg_open_ignore: got %b want %b", status(), e); end
    exp_q.push_back(st(1, 0, 0, 1, 0));
    pulse_prog();
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL pg_enter: got %b want %b", status(), e); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i < 3 ? st(1, 0, 0, 1, i + 1) : st(1, 0, 0, 0, 0));
      strobe_digit(n[15-4*i -: 4]);
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL pg_d%0d: got %b want %b", i, status(), e); end
    end
    pulse_relock();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i < 3 ? st(0, 0, 0, 0, i + 1) : st(0, 1, 0, 0, 0));
      strobe_digit(c[15-4*i -: 4]);
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL pg_oldcode_d%0d: got %b want %b", i, status(), e); end
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i < 3 ? st(0, 0, 0, 0, i + 1) : st(1, 0, 0, 0, 0));
      strobe_digit(n[15-4*i -: 4]);
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL pg_newcode_d%0d: got %b want %b", i, status(), e); end
    end
  endtask

  task automatic test_prog_abort();
    logic [6:0] e;
    logic [15:0] n = 16'h3377;
    pulse_prog();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(st(1, 0, 0, 1, i + 1));
      strobe_digit(4'(i + 1));
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL ab_d%0d: got %b want %b", i, status(), e); end
    end
    exp_q.push_back(st(0, 0, 0, 0, 0));
    pulse_relock();
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL ab_relock: got %b want %b", status(), e); end
    exp_q.push_back(st(0, 0, 0, 0, 0));
    pulse_prog();
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL ab_prog_idle: got %b want %b", status(), e); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i < 3 ? st(0, 0, 0, 0, i + 1) : st(1, 0, 0, 0, 0));
      strobe_digit(n[15-4*i -: 4]);
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL ab_kept_d%0d: got %b want %b", i, status(), e); end
    end
    pulse_relock();
    exp_q.push_back(st(0, 0, 0, 0, 1));
    strobe_digit(4'h3);
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL ab_entry1: got %b want %b", status(), e); end
    exp_q.push_back(st(0, 0, 0, 0, 0));
    @(negedge clk); relock = 1'b1; digit_valid = 1'b1; digit = 4'h3;
    @(negedge clk); relock = 1'b0; digit_valid = 1'b0;
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL ab_relock_digit: got %b want %b", status(), e); end
    exp_q.push_back(st(0, 0, 0, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL ab_no_fail: got %b want %b", status(), e); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    logic [15:0] c = 16'h8421;
    logic [15:0] n = 16'h9999;
    for (int a = 1; a <= 3; a++) begin
      for (int i = 0; i < 4; i++) strobe_digit(4'h0);
      exp_q.push_back(st(0, 1, a == 3, 0, 0));
      e = exp_q.pop_front(); vectors++;
      if (status() !== e) begin miscompares++; $display("FAIL rm_bad_a%0d: got %b want %b", a, status(), e); end
    end
    exp_q.push_back(st(0, 0, 0, 0, 0));
    pulse_reset();
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL rm_lockout_reset: got %b want %b", status(), e); end
    for (int i = 0; i < 4; i++) strobe_digit(c[15-4*i -: 4]);
    exp_q.push_back(st(1, 0, 0, 0, 0));
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL rm_open1: got %b want %b", status(), e); end
    pulse_prog();
    for (int i = 0; i < 4; i++) strobe_digit(n[15-4*i -: 4]);
    pulse_prog();
    exp_q.push_back(st(1, 0, 0, 1, 1));
    strobe_digit(4'h1);
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL rm_prog_d0: got %b want %b", status(), e); end
    exp_q.push_back(st(0, 0, 0, 0, 0));
    pulse_reset();
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL rm_prog_reset: got %b want %b", status(), e); end
    for (int i = 0; i < 4; i++) strobe_digit(n[15-4*i -: 4]);
    exp_q.push_back(st(0, 1, 0, 0, 0));
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL rm_prog_code_gone: got %b want %b", status(), e); end
    for (int i = 0; i < 4; i++) strobe_digit(c[15-4*i -: 4]);
    exp_q.push_back(st(1, 0, 0, 0, 0));
    e = exp_q.pop_front(); vectors++;
    if (status() !== e) begin miscompares++; $display("FAIL rm_default_open: got %b want %b", status(), e); end
    pulse_relock();
  endtask

  initial begin
    test_reset();
    test_open();
    test_fail_lockout();
    test_timeout();
    test_program();
    test_prog_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
